// File: rtl/fre_scan_pkg.sv
// fre_scan_pkg: shared state encoding, widths and helpers for the
// multi-channel frequency scan controller.
package fre_scan_pkg;

    localparam int FRE_W = 20;
    localparam int TMO_W = 26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_SETTLE,
        S_MEASURE,
        S_WRITE
    } state_t;

    function automatic logic [3:0] lowest_ch(input logic [15:0] mask);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fre_scan_pick.sv
// fre_scan_pick: finds the next enabled channel strictly above the
// current one; flags when no enabled channel remains.
module fre_scan_pick #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic [CH_NUM-1:0] mask,
    input  logic [CH_W-1:0]   ch,
    output logic [CH_W-1:0]   nxt,
    output logic              none
);

    always_comb begin
        nxt  = ch;
        none = 1'b1;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) begin
                nxt  = CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fre_scan_ctrl.sv
// fre_scan_ctrl: scans enabled frequency channels through one shared meter.
// Define FRE_SCAN_DISCARD_EN to drop the first meter result of each channel.
module fre_scan_ctrl
    import fre_scan_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 60_000_000
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      continuous_i,
    input  logic [CH_NUM-1:0]         ch_mask_i,
    input  logic [CH_NUM-1:0]         fre_hz_i,
    output logic                      meas_fre_o,
    output logic                      meas_rst_n_o,
    input  logic                      meas_done_i,
    input  logic [FRE_W-1:0]          meas_khz_i,
    input  logic                      meas_low_i,
    output logic                      res_wr_o,
    output logic [$clog2(CH_NUM)-1:0] res_ch_o,
    output logic [FRE_W-1:0]          res_khz_o,
    output logic                      res_low_o,
    output logic                      res_tmo_o,
    output logic                      busy_o,
    output logic                      scan_done_o
);

    localparam int               CH_W     = $clog2(CH_NUM);
    localparam logic [7:0]       SET_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t             state, state_n;
    logic [CH_NUM-1:0]  mask_q, mask_n;
    logic [CH_W-1:0]    ch, ch_n;
    logic [CH_W-1:0]    pick_ch, first_ch;
    logic               pick_none;
    logic [7:0]         set_cnt, set_cnt_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic [CH_W-1:0]    res_ch_n;
    logic [FRE_W-1:0]   res_khz_n;
    logic               res_low_n, res_tmo_n;
    logic               capture;

`ifdef FRE_SCAN_DISCARD_EN
    logic seen, seen_n;
    assign capture = meas_done_i && seen;
`else
    assign capture = meas_done_i;
`endif

    assign first_ch = CH_W'(lowest_ch(16'(ch_mask_i)));

    fre_scan_pick #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_pick (
        .mask (mask_q),
        .ch   (ch),
        .nxt  (pick_ch),
        .none (pick_none)
    );

    assign busy_o       = (state != S_IDLE);
    assign meas_rst_n_o = (state == S_MEASURE);
    assign res_wr_o     = (state == S_WRITE);
    assign meas_fre_o   = fre_hz_i[ch];

    always_comb begin
        state_n     = state;
        mask_n      = mask_q;
        ch_n        = ch;
        set_cnt_n   = set_cnt;
        tmo_cnt_n   = tmo_cnt;
        res_ch_n    = res_ch_o;
        res_khz_n   = res_khz_o;
        res_low_n   = res_low_o;
        res_tmo_n   = res_tmo_o;
        scan_done_o = 1'b0;
`ifdef FRE_SCAN_DISCARD_EN
        seen_n      = seen;
`endif
        unique case (state)
            S_IDLE: begin
                if (start_i && (|ch_mask_i)) begin
                    mask_n    = ch_mask_i;
                    ch_n      = first_ch;
                    set_cnt_n = '0;
                    state_n   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (set_cnt == SET_LAST) begin
                    tmo_cnt_n = '0;
`ifdef FRE_SCAN_DISCARD_EN
                    seen_n    = 1'b0;
`endif
                    state_n   = S_MEASURE;
                end else begin
                    set_cnt_n = set_cnt + 8'd1;
                end
            end
            S_MEASURE: begin
                // a result landing on the timeout cycle still counts as a result
                if (capture) begin
                    res_ch_n  = ch;
                    res_khz_n = meas_khz_i;
                    res_low_n = meas_low_i;
                    res_tmo_n = 1'b0;
                    state_n   = S_WRITE;
                end else if (tmo_cnt == TMO_LAST) begin
                    res_ch_n  = ch;
                    res_khz_n = '0;
                    res_low_n = 1'b0;
                    res_tmo_n = 1'b1;
                    state_n   = S_WRITE;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
`ifdef FRE_SCAN_DISCARD_EN
                    seen_n    = seen | meas_done_i;
`endif
                end
            end
            S_WRITE: begin
                state_n = S_PICK;
            end
            S_PICK: begin
                set_cnt_n = '0;
                if (!pick_none) begin
                    ch_n    = pick_ch;
                    state_n = S_SETTLE;
                end else begin
                    scan_done_o = 1'b1;
                    if (continuous_i && (|ch_mask_i)) begin
                        mask_n  = ch_mask_i;
                        ch_n    = first_ch;
                        state_n = S_SETTLE;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            ch        <= '0;
            set_cnt   <= '0;
            tmo_cnt   <= '0;
            res_ch_o  <= '0;
            res_khz_o <= '0;
            res_low_o <= 1'b0;
            res_tmo_o <= 1'b0;
`ifdef FRE_SCAN_DISCARD_EN
            seen      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            mask_q    <= mask_n;
            ch        <= ch_n;
            set_cnt   <= set_cnt_n;
            tmo_cnt   <= tmo_cnt_n;
            res_ch_o  <= res_ch_n;
            res_khz_o <= res_khz_n;
            res_low_o <= res_low_n;
            res_tmo_o <= res_tmo_n;
`ifdef FRE_SCAN_DISCARD_EN
            seen      <= seen_n;
`endif
        end
    end

endmodule

// File: tb/tb_fre_scan_ctrl.sv
// tb_fre_scan_ctrl: randomized bench; expected writes come from the scan
// rules (ascending enabled channels, one result or timeout per channel).
`timescale 1ns/1ps
module tb_fre_scan_ctrl;

    localparam int CH = 4;
    localparam int SC = 4;
    localparam int TO = 1000;
`ifdef FRE_SCAN_DISCARD_EN
    localparam int MIN_D = 1;
`else
    localparam int MIN_D = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          continuous_i = 1'b0;
    logic [CH-1:0] ch_mask_i = '0;
    logic [CH-1:0] fre_hz_i = '0;
    logic          meas_fre_o;
    logic          meas_rst_n_o;
    logic          meas_done_i = 1'b0;
    logic [19:0]   meas_khz_i = '0;
    logic          meas_low_i = 1'b0;
    logic          res_wr_o;
    logic [1:0]    res_ch_o;
    logic [19:0]   res_khz_o;
    logic          res_low_o;
    logic          res_tmo_o;
    logic          busy_o;
    logic          scan_done_o;

    int checks = 0;
    int failures = 0;

    int          dly_a [CH];
    logic [19:0] khz_a [CH];
    logic        low_a [CH];

    fre_scan_ctrl #(
        .CH_NUM      (CH),
        .SETTLE_CYC  (SC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .ch_mask_i    (ch_mask_i),
        .fre_hz_i     (fre_hz_i),
        .meas_fre_o   (meas_fre_o),
        .meas_rst_n_o (meas_rst_n_o),
        .meas_done_i  (meas_done_i),
        .meas_khz_i   (meas_khz_i),
        .meas_low_i   (meas_low_i),
        .res_wr_o     (res_wr_o),
        .res_ch_o     (res_ch_o),
        .res_khz_o    (res_khz_o),
        .res_low_o    (res_low_o),
        .res_tmo_o    (res_tmo_o),
        .busy_o       (busy_o),
        .scan_done_o  (scan_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [27:0] outs();
        return {meas_rst_n_o, res_wr_o, scan_done_o, busy_o,
                res_ch_o, res_khz_o, res_low_o, res_tmo_o};
    endfunction

    task automatic rand_resp(input int tmo_pct);
        for (int i = 0; i < CH; i++) begin
            if (int'($urandom_range(0, 99)) < tmo_pct) dly_a[i] = -1;
            else dly_a[i] = int'($urandom_range(MIN_D, 40));
            khz_a[i] = 20'($urandom);
            low_a[i] = 1'($urandom);
        end
    endtask

    // Entered on the first SETTLE cycle of channel c; leaves on the PICK cycle.
    task automatic do_channel(input int c, input bit last, input bit disturb);
        int n;
        int k;
        int exp_k;
        bit tmo;
        logic [19:0] exp_khz;
        tmo = (dly_a[c] < 0);
        exp_k = tmo ? TO : dly_a[c] + 1;
        exp_khz = tmo ? 20'd0 : khz_a[c];
        n = 0;
        while (meas_rst_n_o !== 1'b1 && n < SC + 8) begin
            fre_hz_i = CH'($urandom);
            meas_done_i = disturb ? 1'($urandom) : 1'b0;
            #1;
            checks++;
            if (meas_fre_o !== fre_hz_i[c]) begin
                failures++;
                $display("FAIL settle_route ch=%0d got=%b exp=%b", c, meas_fre_o, fre_hz_i[c]);
            end
            checks++;
            if (res_wr_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL settle_state ch=%0d wr=%b busy=%b exp wr=0 busy=1", c, res_wr_o, busy_o);
            end
            tick();
            n++;
        end
        meas_done_i = 1'b0;
        checks++;
        if (n != SC) begin
            failures++;
            $display("FAIL settle_len ch=%0d got=%0d exp=%0d", c, n, SC);
        end
        k = 0;
        while (res_wr_o !== 1'b1 && k < TO + 8) begin
            meas_done_i = 1'b0;
            meas_khz_i = 20'($urandom);
            meas_low_i = 1'($urandom);
            if (!tmo && k == dly_a[c]) begin
                meas_done_i = 1'b1;
                meas_khz_i = khz_a[c];
                meas_low_i = low_a[c];
            end
`ifdef FRE_SCAN_DISCARD_EN
            else if (k == 0) meas_done_i = 1'b1;
`endif
            if (disturb && k == 0) begin
                start_i = 1'b1;
                ch_mask_i = CH'($urandom);
            end
            tick();
            start_i = 1'b0;
            k++;
        end
        meas_done_i = 1'b0;
        checks++;
        if (res_wr_o !== 1'b1 || k != exp_k) begin
            failures++;
            $display("FAIL write_time ch=%0d wr=%b got=%0d exp=%0d", c, res_wr_o, k, exp_k);
        end
        checks++;
        if (res_ch_o !== 2'(c)) begin
            failures++;
            $display("FAIL res_ch got=%0d exp=%0d", res_ch_o, c);
        end
        checks++;
        if (res_khz_o !== exp_khz || res_tmo_o !== tmo) begin
            failures++;
            $display("FAIL res_val ch=%0d got khz=%0d tmo=%b exp khz=%0d tmo=%b",
                     c, res_khz_o, res_tmo_o, exp_khz, tmo);
        end
        if (!tmo) begin
            checks++;
            if (res_low_o !== low_a[c]) begin
                failures++;
                $display("FAIL res_low ch=%0d got=%b exp=%b", c, res_low_o, low_a[c]);
            end
        end
        tick();
        checks++;
        if (res_wr_o !== 1'b0 || scan_done_o !== last || busy_o !== 1'b1 || res_khz_o !== exp_khz) begin
            failures++;
            $display("FAIL pick ch=%0d wr=%b done=%b busy=%b khz=%0d exp wr=0 done=%b busy=1 khz=%0d",
                     c, res_wr_o, scan_done_o, busy_o, res_khz_o, last, exp_khz);
        end
    endtask

    task automatic run_scan(input logic [CH-1:0] mask, input bit disturb);
        int chs[$];
        for (int i = 0; i < CH; i++) if (mask[i]) chs.push_back(i);
        ch_mask_i = mask;
        continuous_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || meas_rst_n_o !== 1'b0) begin
            failures++;
            $display("FAIL start_latency busy=%b rst_n=%b exp busy=1 rst_n=0", busy_o, meas_rst_n_o);
        end
        foreach (chs[j]) begin
            if (j > 0) tick();
            do_channel(chs[j], j == chs.size() - 1, disturb);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || scan_done_o !== 1'b0 || meas_rst_n_o !== 1'b0) begin
            failures++;
            $display("FAIL end_idle busy=%b done=%b rst_n=%b exp all 0", busy_o, scan_done_o, meas_rst_n_o);
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (outs() !== 28'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", outs());
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (outs() !== 28'd0) begin
            failures++;
            $display("FAIL reset_release got=%h exp=0", outs());
        end
    endtask

    task automatic test_order();
        rand_resp(0);
        dly_a[1] = 3;
        khz_a[1] = 20'd1234;
        low_a[1] = 1'b0;
        run_scan(4'b1011, 1'b0);
    endtask

    task automatic test_timeout();
        rand_resp(0);
        dly_a[2] = -1;
        run_scan(4'b0100, 1'b0);
    endtask

    task automatic test_done_vs_timeout();
        rand_resp(0);
        dly_a[0] = TO - 1;
        run_scan(4'b0001, 1'b0);
    endtask

    task automatic test_random();
        logic [CH-1:0] m;
        for (int it = 0; it < 12; it++) begin
            m = CH'($urandom_range(1, (1 << CH) - 1));
            rand_resp(10);
            run_scan(m, 1'b1);
        end
    endtask

    task automatic test_continuous();
        for (int mode = 0; mode < 2; mode++) begin
            ch_mask_i = 4'b0001;
            continuous_i = 1'b1;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            for (int it = 0; it < 3; it++) begin
                if (it > 0) tick();
                if (it == 2) begin
                    if (mode == 0) continuous_i = 1'b0;
                    else ch_mask_i = '0;
                end
                rand_resp(0);
                do_channel(0, 1'b1, 1'b0);
            end
            tick();
            checks++;
            if (busy_o !== 1'b0 || scan_done_o !== 1'b0) begin
                failures++;
                $display("FAIL cont_stop mode=%0d busy=%b done=%b exp 0", mode, busy_o, scan_done_o);
            end
            continuous_i = 1'b0;
        end
    endtask

    task automatic test_rst_mid();
        bit wr_seen;
        rand_resp(0);
        ch_mask_i = 4'b1111;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 28'd0) begin
            failures++;
            $display("FAIL rst_async got=%h exp=0", outs());
        end
        tick();
        checks++;
        if (outs() !== 28'd0) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=0", outs());
        end
        rst = 1'b0;
        ch_mask_i = '0;
        start_i = 1'b1;
        meas_done_i = 1'b1;
        tick();
        start_i = 1'b0;
        meas_done_i = 1'b0;
        wr_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy_o !== 1'b0 || res_wr_o !== 1'b0 || meas_rst_n_o !== 1'b0) wr_seen = 1'b1;
            tick();
        end
        checks++;
        if (wr_seen) begin
            failures++;
            $display("FAIL mask_zero_start activity=1 exp=0");
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_timeout();
        test_done_vs_timeout();
        test_continuous();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fre_scan_ctrl.md
FRE_SCAN_CTRL -- requirements
Module: fre_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; parameters and ports are listed in REQ-002..REQ-019.
REQ-002 Parameter CH_NUM, default 4, SHALL set the number of frequency input channels (2..16).
REQ-003 Parameter SETTLE_CYC, default 16, SHALL set the cycles the shared meter is held in reset after a channel switch (1..255).
REQ-004 Parameter TIMEOUT_CYC, default 60_000_000, SHALL set the per-channel measurement timeout in cycles (26-bit).
REQ-005 clk_i  in  1  system clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start_i  in  1  single-cycle pulse that starts a scan.
REQ-008 continuous_i  in  1  when high, the block restarts the scan automatically.
REQ-009 ch_mask_i  in  CH_NUM  enabled channels; bit n enables channel n.
REQ-010 fre_hz_i  in  CH_NUM  raw frequency inputs.
REQ-011 meas_fre_o  out  1  selected channel routed to the shared meter.
REQ-012 meas_rst_n_o  out  1  active-low reset to the shared meter.
REQ-013 meas_done_i  in  1  one-cycle pulse when the meter latches a new result.
REQ-014 meas_khz_i  in  20  meter result value.
REQ-015 meas_low_i  in  1  meter low-frequency flag; 1 means meas_khz_i is in Hz.
REQ-016 res_wr_o  out  1  one-cycle result write strobe.
REQ-017 res_ch_o / res_khz_o / res_low_o / res_tmo_o  out  clog2(CH_NUM) / 20 / 1 / 1  result channel, value, unit flag, timeout flag.
REQ-018 busy_o  out  1  high while a scan is in progress.
REQ-019 scan_done_o  out  1  one-cycle pulse after the last enabled channel is written.

Function
REQ-020 The FSM SHALL have states IDLE, PICK, SETTLE, MEASURE, WRITE.
REQ-021 IDLE: start_i with a nonzero ch_mask_i SHALL latch the mask, set ch=lowest enabled channel and go to SETTLE; start_i with ch_mask_i==0 SHALL be ignored.
REQ-022 SETTLE: the block SHALL drive meas_rst_n_o=0 for exactly SETTLE_CYC cycles with meas_fre_o=fre_hz_i[ch], then go to MEASURE with meas_rst_n_o=1.
REQ-023 MEASURE: the block SHALL clear a 26-bit timeout counter on entry; meas_done_i SHALL capture meas_khz_i/meas_low_i and go to WRITE; counter==TIMEOUT_CYC-1 SHALL go to WRITE with res_khz_o=0, res_tmo_o=1.
REQ-024 meas_done_i and timeout in the same cycle: done SHALL win (res_tmo_o=0).
REQ-025 meas_done_i outside MEASURE SHALL be ignored.
REQ-026 WRITE: the block SHALL assert res_wr_o for one cycle, the cycle after capture; res_* SHALL hold until the next write; then go to PICK.
REQ-027 PICK: the block SHALL select the next enabled channel above ch in the latched mask and go to SETTLE; if none remains, pulse scan_done_o and, if continuous_i=1 and ch_mask_i!=0, re-latch the mask and restart from the lowest channel, else go to IDLE.
REQ-028 start_i while busy SHALL be ignored; ch_mask_i changes mid-scan SHALL have no effect until the next latch.
REQ-029 busy_o SHALL be high in every state except IDLE.
REQ-030 Latency SHALL be start_i at cycle 0 -> busy_o=1 and meas_rst_n_o=0 from cycle 1.

Reset
REQ-031 On reset: state=IDLE, meas_rst_n_o=0, res_wr_o=0, scan_done_o=0, busy_o=0, res_ch_o=0, res_khz_o=0, res_low_o=0, res_tmo_o=0, all counters 0.
REQ-032 Reset asserted mid-scan SHALL abort immediately with no res_wr_o pulse.
REQ-033 meas_rst_n_o SHALL be 0 in IDLE.

Configuration
REQ-034 With FRE_SCAN_DISCARD_EN defined, the first meas_done_i in each MEASURE SHALL be discarded, the timeout counter SHALL not restart, and the second meas_done_i SHALL be captured.
REQ-035 Without FRE_SCAN_DISCARD_EN, the first meas_done_i SHALL be captured.

Structure
REQ-036 Package fre_scan_pkg SHALL hold the state encoding, FRE_W=20 and TMO_W=26.
REQ-037 Sub-module fre_scan_pick SHALL be combinational: inputs mask and current ch; outputs next ch and a none-left flag.

Verification
REQ-038 CH_NUM=4, mask=4'b1011, one start -> writes for ch0, ch1, ch3 in order, then one scan_done_o, then busy_o=0.
REQ-039 meas_done_i with khz=1234, low=0 on ch1 -> res_wr_o the next cycle with res_ch_o=1, res_khz_o=1234, res_tmo_o=0.
REQ-040 No meas_done_i, TIMEOUT_CYC=1000 -> res_wr_o exactly 1000 cycles after MEASURE entry with res_khz_o=0, res_tmo_o=1.
REQ-041 continuous_i=1, mask=4'b0001 -> repeated writes for ch0 with scan_done_o pulses; continuous_i=0 -> IDLE after the current scan.
REQ-042 rst asserted during SETTLE -> all outputs equal their reset values next cycle; start with mask=0 -> busy_o stays 0.
REQ-043 With FRE_SCAN_DISCARD_EN defined, two done pulses (khz=7 then khz=9) -> one write with res_khz_o=9.
